frame_scanout: RTL and testbench
================================

# frame_scanout

Parametrised frame-buffer scan-out engine sitting between the HPS F2H SDRAM port (Avalon-MM burst read master, 64-bit) and the LCD timing generator. At each frame start it latches a software-selectable base address, which gives double buffering. It prefetches the frame through a FIFO with credit-based burst throttling and emits one registered 24-bit pixel per active LCD tick. It recovers cleanly from early frame restarts and from FIFO underflow, and reports frame and underflow counts for the debug overlay.

## Interface
- WIDTH, 800: active pixels per line; WIDTH*HEIGHT must be even.
- HEIGHT, 480: active lines per frame.
- BURST_LENGTH, 32: maximum 64-bit words per read burst, 1..128.
- FIFO_DEPTH, 256: FIFO depth in 64-bit words; power of two, ≥ 2*BURST_LENGTH.
- ADDRESS_WIDTH, 29: Avalon word-address width.

Ports:
- clock  in  1  system clock (50 MHz).
- reset_n  in  1  asynchronous, active-low reset.
- base_address  in  ADDRESS_WIDTH  word address of the frame to show; sampled only on lcd_next_frame.
- address  out  ADDRESS_WIDTH  Avalon burst start address.
- burstcount  out  8  Avalon burst length.
- read  out  1  Avalon read request.
- waitrequest  in  1  Avalon stall.
- readdata  in  64  Avalon read data.
- readdatavalid  in  1  Avalon data strobe.
- lcd_tick  in  1  pixel-rate enable.
- lcd_next_frame  in  1  one-clock pulse, frame start, precedes first active pixel.
- lcd_data_enable  in  1  current LCD position is active; qualified by lcd_tick.
- lcd_red, lcd_green, lcd_blue  out  8 each  registered pixel colour.
- frame_count  out  16  frames started, wraps.
- underflow_count  out  16  frames that underflowed, saturates at 0xFFFF.

## Operation
- Each word holds 2 pixels, low half first. Within a 32-bit pixel: [7:0] R, [15:8] G, [23:16] B, [31:24] ignored.
- TOTAL_WORDS = WIDTH*HEIGHT/2. Bursts are BURST_LENGTH words; the final burst carries the remainder.
- Credit rule: a burst may issue only when FIFO occupancy + outstanding words + burst size ≤ FIFO_DEPTH. Outstanding words increase on burst acceptance and decrease per readdatavalid.
- State machine:
  - IDLE: entered after reset. lcd_next_frame goes to START.
  - START: latch base_address; clear word pointer; increment frame_count; clear underflow flag. Go to THROTTLE.
  - THROTTLE: when the credit rule passes, go to ISSUE.
  - ISSUE: read=1 with address and burstcount held stable until waitrequest=0. On acceptance, go to THROTTLE, or to DONE if all words are requested.
  - DONE: wait for lcd_next_frame.
  - FLUSH: entered when lcd_next_frame arrives in THROTTLE, ISSUE, or DONE with the FIFO non-empty. Any pending ISSUE burst completes its acceptance first. Discard returning data until outstanding=0, clear the FIFO, then go to START.
- A lcd_next_frame arriving in FLUSH is remembered, and START runs once.
- Pixel output: on lcd_tick with lcd_data_enable=1, output the next pixel. The FIFO pops after the high pixel is used.
- Underflow: a pixel is needed and the FIFO is empty.
  - Output 0 for the remainder of the frame.
  - Increment underflow_count once for that frame.
  - Stop issuing and go to FLUSH, then wait in IDLE for lcd_next_frame.
- With lcd_data_enable=0 on a tick, colours go to 0.
- Address arithmetic: base + word pointer, modulo 2^ADDRESS_WIDTH.

## Timing
- Reset values: read=0, address=0, burstcount=0, all colours 0, both counters 0, state IDLE, FIFO empty, outstanding=0.
- Colours update on the clock edge where lcd_tick=1, so the latency is one LCD tick. The parent delays data_enable by one tick to match.
- The first read is asserted 2 clocks after lcd_next_frame (START, THROTTLE, then ISSUE).
- Back-to-back bursts are possible with one THROTTLE cycle between acceptances.
- FIFO push and pop in the same clock leave occupancy unchanged. Full plus push cannot occur by the credit rule; the bench asserts this.
- Asynchronous reset mid-burst abandons outstanding reads. The interconnect is reset together with this block.

## Structure
- A shared package holds the state encoding, the pixel byte-lane constants, and the TOTAL_WORDS and remainder-burst computation functions.
- One sub-module, scanout_fifo: a synchronous show-ahead FIFO with count output and a synchronous clear input. Width 64, depth FIFO_DEPTH.

## Test plan
Bench parameters: WIDTH=8, HEIGHT=2, BURST_LENGTH=4, FIFO_DEPTH=16.
- Reset, then lcd_next_frame with base=0x100. Expect bursts (0x100,4) and (0x104,4), frame_count=1, then DONE.
- WIDTH=10, HEIGHT=1 (5 words). Expect bursts of 4 then 1 at 0x104.
- waitrequest held high 5 clocks. Expect address, burstcount and read held stable, and no duplicate burst.
- Word 0x00_332211_00_CCBBAA at position 0, two active ticks. Expect RGB=AA,BB,CC and then 11,22,33.
- Memory model delays readdatavalid 40 clocks. Expect underflow_count=1, black output to the end of the frame, and correct pixels after the next lcd_next_frame.
- lcd_next_frame mid-burst with base changed to 0x200. Expect the old data discarded, a FLUSH wait for outstanding=0, then a burst at 0x200.

Source files
------------

// File: rtl/frame_scanout_pkg.sv
// rtl/frame_scanout_pkg.sv - shared state encoding, pixel lanes and burst sizing for frame_scanout
package frame_scanout_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_START    = 3'd1,
    ST_THROTTLE = 3'd2,
    ST_ISSUE    = 3'd3,
    ST_DONE     = 3'd4,
    ST_FLUSH    = 3'd5
  } scan_state_e;

  localparam int RED_LSB   = 0;
  localparam int GREEN_LSB = 8;
  localparam int BLUE_LSB  = 16;

  function automatic int total_words(input int width, input int height);
    return (width * height) / 2;
  endfunction

  // Full bursts until fewer than burst_length words remain; the last burst carries the rest.
  function automatic int burst_words(input int remaining, input int burst_length);
    return (remaining < burst_length) ? remaining : burst_length;
  endfunction

endpackage

// File: rtl/scanout_fifo.sv
// rtl/scanout_fifo.sv - show-ahead FIFO with occupancy count and synchronous clear
module scanout_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 256
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       clear_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           data_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [CW-1:0]    count_q;
  logic             full, do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_q];
  assign count_o = count_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else if (clear_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !clear_i) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/frame_scanout.sv
// rtl/frame_scanout.sv - frame-buffer scan-out: credit-throttled Avalon burst reads feeding LCD pixels
module frame_scanout
  import frame_scanout_pkg::*;
#(
  parameter int WIDTH         = 800,
  parameter int HEIGHT        = 480,
  parameter int BURST_LENGTH  = 32,
  parameter int FIFO_DEPTH    = 256,
  parameter int ADDRESS_WIDTH = 29
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [ADDRESS_WIDTH-1:0] base_address,
  output logic [ADDRESS_WIDTH-1:0] address,
  output logic [7:0]               burstcount,
  output logic                     read,
  input  logic                     waitrequest,
  input  logic [63:0]              readdata,
  input  logic                     readdatavalid,
  input  logic                     lcd_tick,
  input  logic                     lcd_next_frame,
  input  logic                     lcd_data_enable,
  output logic [7:0]               lcd_red,
  output logic [7:0]               lcd_green,
  output logic [7:0]               lcd_blue,
  output logic [15:0]              frame_count,
  output logic [15:0]              underflow_count
);
  localparam int TOTAL_WORDS = total_words(WIDTH, HEIGHT);
  localparam int PTR_W       = $clog2(TOTAL_WORDS + 1);
  localparam int CW          = $clog2(FIFO_DEPTH) + 1;

  scan_state_e              state_q;
  logic [ADDRESS_WIDTH-1:0] base_q, addr_q;
  logic [PTR_W-1:0]         wptr_q, remain;
  logic [CW-1:0]            outst_q, fifo_count;
  logic [7:0]               bcnt_q, next_burst, red_q, green_q, blue_q;
  logic [15:0]              fcnt_q, ucnt_q;
  logic                     read_q, half_q, uf_q, restart_q, pend_q;
  logic [63:0]              fifo_dout;
  logic [23:0]              pixel;
  logic                     fifo_empty, fifo_push, fifo_pop, fifo_clear;
  logic                     credit_ok, accept, need_pixel, scanning, underflow_evt, abort;
  logic                     unused_alpha;

  assign remain        = PTR_W'(TOTAL_WORDS) - wptr_q;
  assign next_burst    = 8'(burst_words(int'(remain), BURST_LENGTH));
  assign credit_ok     = (int'(fifo_count) + int'(outst_q) + int'(next_burst)) <= FIFO_DEPTH;
  assign accept        = (state_q == ST_ISSUE) && !waitrequest;
  assign need_pixel    = lcd_tick && lcd_data_enable;
  assign scanning      = (state_q == ST_THROTTLE) || (state_q == ST_ISSUE) || (state_q == ST_DONE);
  assign underflow_evt = need_pixel && fifo_empty && !uf_q && scanning;
  assign abort         = lcd_next_frame || underflow_evt;
  // Data returning for a superseded frame is dropped rather than queued.
  assign fifo_push     = readdatavalid && (state_q != ST_FLUSH);
  assign fifo_pop      = need_pixel && half_q && !fifo_empty && !uf_q;
  assign fifo_clear    = (state_q == ST_FLUSH) && (outst_q == '0);
  assign pixel         = half_q ? fifo_dout[55:32] : fifo_dout[23:0];
  assign unused_alpha  = ^{fifo_dout[63:56], fifo_dout[31:24]};

  scanout_fifo #(.WIDTH(64), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (clock),
    .rst_ni  (reset_n),
    .clear_i (fifo_clear),
    .push_i  (fifo_push),
    .data_i  (readdata),
    .pop_i   (fifo_pop),
    .data_o  (fifo_dout),
    .count_o (fifo_count),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      base_q    <= '0;
      addr_q    <= '0;
      wptr_q    <= '0;
      outst_q   <= '0;
      bcnt_q    <= '0;
      read_q    <= 1'b0;
      half_q    <= 1'b0;
      uf_q      <= 1'b0;
      restart_q <= 1'b0;
      pend_q    <= 1'b0;
      red_q     <= '0;
      green_q   <= '0;
      blue_q    <= '0;
      fcnt_q    <= '0;
      ucnt_q    <= '0;
    end else begin
      outst_q <= outst_q + (accept ? CW'(bcnt_q) : CW'(0)) - CW'(readdatavalid);

      if (lcd_tick) begin
        if (lcd_data_enable && !fifo_empty && !uf_q) begin
          red_q   <= pixel[RED_LSB +: 8];
          green_q <= pixel[GREEN_LSB +: 8];
          blue_q  <= pixel[BLUE_LSB +: 8];
          half_q  <= !half_q;
        end else begin
          red_q   <= '0;
          green_q <= '0;
          blue_q  <= '0;
        end
      end

      if (underflow_evt) begin
        uf_q <= 1'b1;
        if (ucnt_q != 16'hFFFF) ucnt_q <= ucnt_q + 16'd1;
      end
      if (lcd_next_frame && (scanning || state_q == ST_FLUSH)) restart_q <= 1'b1;

      case (state_q)
        ST_IDLE: if (lcd_next_frame) state_q <= ST_START;
        ST_START: begin
          base_q    <= base_address;
          wptr_q    <= '0;
          fcnt_q    <= fcnt_q + 16'd1;
          uf_q      <= 1'b0;
          half_q    <= 1'b0;
          restart_q <= 1'b0;
          pend_q    <= 1'b0;
          state_q   <= ST_THROTTLE;
        end
        ST_THROTTLE, ST_DONE: begin
          if (abort) begin
            state_q <= (lcd_next_frame && fifo_empty && outst_q == '0) ? ST_START : ST_FLUSH;
          end else if (state_q == ST_THROTTLE && credit_ok) begin
            addr_q  <= base_q + ADDRESS_WIDTH'(wptr_q);
            bcnt_q  <= next_burst;
            read_q  <= 1'b1;
            state_q <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          // A started burst must be accepted before the restart or underflow takes effect.
          if (abort) pend_q <= 1'b1;
          if (!waitrequest) begin
            read_q <= 1'b0;
            wptr_q <= wptr_q + PTR_W'(bcnt_q);
            if (pend_q || abort)
              state_q <= ST_FLUSH;
            else if (wptr_q + PTR_W'(bcnt_q) == PTR_W'(TOTAL_WORDS))
              state_q <= ST_DONE;
            else
              state_q <= ST_THROTTLE;
          end
        end
        ST_FLUSH: if (outst_q == '0) state_q <= (restart_q || lcd_next_frame) ? ST_START : ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign address         = addr_q;
  assign burstcount      = bcnt_q;
  assign read            = read_q;
  assign lcd_red         = red_q;
  assign lcd_green       = green_q;
  assign lcd_blue        = blue_q;
  assign frame_count     = fcnt_q;
  assign underflow_count = ucnt_q;

endmodule

// File: tb/tb_frame_scanout.sv
// tb/tb_frame_scanout.sv - directed self-checking bench for frame_scanout
module tb_frame_scanout;
  import frame_scanout_pkg::*;
  localparam int AW = 29;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          reset_n;
  logic [AW-1:0] base_address, address;
  logic [7:0]    burstcount, lcd_red, lcd_green, lcd_blue;
  logic          read, waitrequest, lcd_tick, lcd_next_frame, lcd_data_enable;
  logic [63:0]   readdata = 64'h0;
  logic          readdatavalid = 1'b0;
  logic [15:0]   frame_count, underflow_count;

  logic [AW-1:0] base_b, address_b;
  logic [7:0]    burstcount_b, red_b, green_b, blue_b;
  logic          read_b, nf_b;
  logic          waitrequest_b = 1'b0, rdv_b = 1'b0, tick_b = 1'b0, de_b = 1'b0;
  logic [63:0]   readdata_b = 64'h0;
  logic [15:0]   fc_b, uc_b;

  frame_scanout #(.WIDTH(8), .HEIGHT(2), .BURST_LENGTH(4), .FIFO_DEPTH(16), .ADDRESS_WIDTH(AW)) dut (
    .clock(clock), .reset_n(reset_n), .base_address(base_address), .address(address),
    .burstcount(burstcount), .read(read), .waitrequest(waitrequest), .readdata(readdata),
    .readdatavalid(readdatavalid), .lcd_tick(lcd_tick), .lcd_next_frame(lcd_next_frame),
    .lcd_data_enable(lcd_data_enable), .lcd_red(lcd_red), .lcd_green(lcd_green),
    .lcd_blue(lcd_blue), .frame_count(frame_count), .underflow_count(underflow_count));

  frame_scanout #(.WIDTH(10), .HEIGHT(1), .BURST_LENGTH(4), .FIFO_DEPTH(16), .ADDRESS_WIDTH(AW)) dut5 (
    .clock(clock), .reset_n(reset_n), .base_address(base_b), .address(address_b),
    .burstcount(burstcount_b), .read(read_b), .waitrequest(waitrequest_b), .readdata(readdata_b),
    .readdatavalid(rdv_b), .lcd_tick(tick_b), .lcd_next_frame(nf_b),
    .lcd_data_enable(de_b), .lcd_red(red_b), .lcd_green(green_b),
    .lcd_blue(blue_b), .frame_count(fc_b), .underflow_count(uc_b));

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int mem_lat = 3;
  logic [AW-1:0] q_addr[$];
  int            q_time[$];
  logic [AW-1:0] log_addr[$], log5_addr[$];
  logic [7:0]    log_len[$], log5_len[$];
  int            log_pend[$];

  function automatic logic [63:0] mem_word(input logic [AW-1:0] a);
    if (a == 29'h100) return 64'h0033_2211_00CC_BBAA;
    return {8'h00, 8'h5A, 8'hC3, a[7:0] + 8'h80, 8'h00, 8'hA5, 8'h3C, a[7:0]};
  endfunction

  always @(posedge clock) cyc++;

  // Avalon memory: returns each accepted word mem_lat clocks later, in order.
  always @(negedge clock) begin
    if (!reset_n) begin
      q_addr.delete();
      q_time.delete();
      readdatavalid = 1'b0;
    end else begin
      if (q_addr.size() > 0 && q_time[0] <= cyc) begin
        readdatavalid = 1'b1;
        readdata = mem_word(q_addr.pop_front());
        void'(q_time.pop_front());
      end else begin
        readdatavalid = 1'b0;
      end
      if (read && !waitrequest) begin
        log_addr.push_back(address);
        log_len.push_back(burstcount);
        log_pend.push_back(q_addr.size());
        for (int i = 0; i < int'(burstcount); i++) begin
          q_addr.push_back(address + AW'(i));
          q_time.push_back(cyc + mem_lat);
        end
      end
      if (read_b && !waitrequest_b) begin
        log5_addr.push_back(address_b);
        log5_len.push_back(burstcount_b);
      end
    end
  end

  always @(negedge clock) begin
    if (reset_n) begin
      assert (!(dut.fifo_push && dut.fifo_count == 16)) else begin
        errors++;
        $error("FAIL fifo_full_push observed push while full expected none");
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic pulse_frame();
    lcd_next_frame = 1'b1;
    step();
    lcd_next_frame = 1'b0;
  endtask

  task automatic pix(input logic de);
    lcd_tick = 1'b1;
    lcd_data_enable = de;
    step();
    lcd_tick = 1'b0;
    lcd_data_enable = 1'b0;
  endtask

  task automatic wait_state(input string tag, input scan_state_e s, input int max);
    for (int i = 0; i < max && dut.state_q != s; i++) step();
    check(tag, 64'(dut.state_q), 64'(s));
  endtask

  function automatic logic [63:0] entry(input int i);
    if (i >= log_addr.size()) return 64'hDEAD;
    return {27'h0, log_addr[i], log_len[i]};
  endfunction

  function automatic logic [63:0] entry5(input int i);
    if (i >= log5_addr.size()) return 64'hDEAD;
    return {27'h0, log5_addr[i], log5_len[i]};
  endfunction

  function automatic logic [23:0] rgb();
    return {lcd_red, lcd_green, lcd_blue};
  endfunction

  int n0;

  initial begin
    reset_n = 1'b0;
    base_address = '0;
    waitrequest = 1'b0;
    lcd_tick = 1'b0;
    lcd_next_frame = 1'b0;
    lcd_data_enable = 1'b0;
    base_b = '0;
    nf_b = 1'b0;
    steps(3);
    check("rst_read", read, 1'b0);
    check("rst_address", address, 0);
    check("rst_burstcount", burstcount, 0);
    check("rst_rgb", rgb(), 0);
    check("rst_frame_count", frame_count, 0);
    check("rst_underflow_count", underflow_count, 0);
    check("rst_state", 64'(dut.state_q), 64'(ST_IDLE));
    reset_n = 1'b1;
    step();

    // Frame 1: two full bursts from 0x100.
    base_address = 29'h100;
    pulse_frame();
    steps(2);
    check("first_read", {read, address, burstcount}, {1'b1, 29'h100, 8'd4});
    wait_state("f1_done", ST_DONE, 50);
    check("f1_burst0", entry(0), {29'h100, 8'd4});
    check("f1_burst1", entry(1), {29'h104, 8'd4});
    check("f1_nbursts", log_addr.size(), 2);
    check("f1_frame_count", frame_count, 1);
    steps(15);

    // Pixel unpacking from the first word, then blanking, then the next word.
    pix(1'b1); check("pix0_low", rgb(), 24'hAABBCC);
    pix(1'b1); check("pix0_high", rgb(), 24'h112233);
    pix(1'b0); check("pix_blank", rgb(), 24'h000000);
    pix(1'b1); check("pix1_low", rgb(), 24'h013CA5);
    step();    check("pix_hold", rgb(), 24'h013CA5);

    // Frame 2: slave stalls for 5 clocks.
    waitrequest = 1'b1;
    base_address = 29'h140;
    n0 = log_addr.size();
    pulse_frame();
    for (int i = 0; i < 20 && !read; i++) step();
    check("wait_read_seen", read, 1'b1);
    for (int k = 0; k < 5; k++) begin
      step();
      check("wait_hold", {read, address, burstcount}, {1'b1, 29'h140, 8'd4});
    end
    check("wait_no_accept", log_addr.size(), n0);
    waitrequest = 1'b0;
    wait_state("f2_done", ST_DONE, 50);
    check("f2_burst0", entry(n0), {29'h140, 8'd4});
    check("f2_burst1", entry(n0 + 1), {29'h144, 8'd4});
    check("f2_nbursts", log_addr.size(), n0 + 2);
    check("f2_frame_count", frame_count, 2);
    steps(15);

    // Frame 3: slow memory causes underflow.
    mem_lat = 40;
    base_address = 29'h180;
    pulse_frame();
    wait_state("f3_done", ST_DONE, 30);
    pix(1'b1);
    check("uf_black", rgb(), 24'h000000);
    check("uf_count", underflow_count, 1);
    check("uf_flush", 64'(dut.state_q), 64'(ST_FLUSH));
    for (int k = 0; k < 5; k++) begin
      pix(1'b1);
      check("uf_tail_black", rgb(), 24'h000000);
      step();
    end
    wait_state("uf_idle", ST_IDLE, 100);
    pix(1'b1);
    check("uf_idle_black", rgb(), 24'h000000);
    check("uf_count_once", underflow_count, 1);

    // Frame 4: recovery with normal latency.
    mem_lat = 3;
    base_address = 29'h100;
    pulse_frame();
    wait_state("f4_done", ST_DONE, 30);
    steps(15);
    pix(1'b1);
    check("f4_pix", rgb(), 24'hAABBCC);
    check("f4_frame_count", frame_count, 4);
    check("f4_underflow_count", underflow_count, 1);

    // Frame 5 restarted mid-burst by frame 6 at a new base.
    mem_lat = 10;
    waitrequest = 1'b1;
    n0 = log_addr.size();
    pulse_frame();
    for (int i = 0; i < 20 && !read; i++) step();
    check("rs_issue", {read, address}, {1'b1, 29'h100});
    base_address = 29'h200;
    pulse_frame();
    step();
    check("rs_stalled", {read, address, burstcount}, {1'b1, 29'h100, 8'd4});
    waitrequest = 1'b0;
    step();
    check("rs_flush", 64'(dut.state_q), 64'(ST_FLUSH));
    check("rs_read_low", read, 1'b0);
    for (int i = 0; i < 60 && log_addr.size() < n0 + 2; i++) step();
    check("rs_old_burst", entry(n0), {29'h100, 8'd4});
    check("rs_new_burst", entry(n0 + 1), {29'h200, 8'd4});
    check("rs_drained", (log_pend.size() > n0 + 1) ? log_pend[n0 + 1] : -1, 0);
    wait_state("f6_done", ST_DONE, 40);
    check("f6_burst1", entry(n0 + 2), {29'h204, 8'd4});
    steps(20);
    pix(1'b1);
    check("f6_pix", rgb(), 24'h003CA5);
    check("f6_frame_count", frame_count, 6);

    // 10x1 instance: 5 words split 4 + 1.
    base_b = 29'h100;
    nf_b = 1'b1;
    step();
    nf_b = 1'b0;
    for (int i = 0; i < 30 && dut5.state_q != ST_DONE; i++) step();
    check("w5_done", 64'(dut5.state_q), 64'(ST_DONE));
    check("w5_burst0", entry5(0), {29'h100, 8'd4});
    check("w5_burst1", entry5(1), {29'h104, 8'd1});
    check("w5_nbursts", log5_addr.size(), 2);
    check("w5_counts", {fc_b, uc_b, red_b, green_b, blue_b}, {16'd1, 16'd0, 24'h0});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
